// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants, types and state encoding for the mux scan sequencer
package mux_scan_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;

  typedef logic [N_CH-1:0]  ch_mask_t;
  typedef logic [SEL_W-1:0] ch_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_next_ch.sv
// rtl/mux_scan_next_ch.sv - finds the lowest enabled channel strictly above an index
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask_i,
  input  logic [SEL_W-1:0] idx_i,
  input  logic             first_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);

  // Scan downwards so the last hit is the lowest qualifying channel;
  // first_i treats the start index as -1 so channel 0 is eligible.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(idx_i)))) begin
        idx_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequences the 16:1 strobed mux and assembles a masked snapshot
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int OUT_INV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [N_CH-1:0]  ch_mask_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic [SEL_W-1:0] mux_sel_o,
  output logic             mux_dis_o,
  input  logic             mux_out_i,
  output logic [N_CH-1:0]  data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam cnt_t SETTLE_C = cnt_t'(SETTLE);
  localparam logic INV      = (OUT_INV != 0);

  state_e          state_q, state_d;
  ch_mask_t        mask_q, mask_d;
  ch_idx_t         sel_q, sel_d;
  cnt_t            cnt_q, cnt_d;
  ch_mask_t        data_q, data_d;
  logic            busy_q, busy_d;
  logic            dis_q, dis_d;
  logic            valid_q, valid_d;

  logic            find_first;
  ch_mask_t        find_mask;
  ch_idx_t         next_idx;
  logic            next_found;

  // In IDLE the finder looks at the incoming mask from index -1; in SCAN it
  // advances past the current select within the latched mask.
  assign find_first = (state_q == ST_IDLE);
  assign find_mask  = find_first ? ch_mask_i : mask_q;

  mux_scan_next_ch u_next_ch (
    .mask_i  (find_mask),
    .idx_i   (sel_q),
    .first_i (find_first),
    .idx_o   (next_idx),
    .found_o (next_found)
  );

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      dis_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      dis_q   <= dis_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: abort dominates in SCAN/DONE, an empty mask skips SCAN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = next_found ? ST_SCAN : ST_DONE;
      end
      ST_SCAN: begin
        if (abort_i)                                 state_d = ST_IDLE;
        else if ((cnt_q == '0) && !next_found)       state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort_i || ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch mask, step the settle counter, capture at cnt==0, advance select.
  always_comb begin
    mask_d = mask_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d = ch_mask_i;
          data_d = '0;
          if (next_found) begin
            sel_d = next_idx;
            cnt_d = SETTLE_C;
          end
        end
      end
      ST_SCAN: begin
        if (!abort_i) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - cnt_t'(1);
          end else begin
            data_d[sel_q] = mux_out_i ^ INV;
            if (next_found) begin
              sel_d = next_idx;
              cnt_d = SETTLE_C;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Registered status outputs follow directly from the upcoming state.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    dis_d   = (state_d != ST_SCAN);
    valid_d = (state_d == ST_DONE);
  end

  assign busy_o    = busy_q;
  assign mux_sel_o = sel_q;
  assign mux_dis_o = dis_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl with behavioural mux models
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int SETTLE = 2;
  localparam int HOLD   = SETTLE + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [N_CH-1:0]  ch_mask_i = '0;
  logic [N_CH-1:0]  mux_data = '0;
  logic             glitch_en = 1'b0;

  logic             a_busy, a_dis, a_valid, a_mux_out;
  logic [SEL_W-1:0] a_sel;
  logic [N_CH-1:0]  a_data;
  logic             b_busy, b_dis, b_valid, b_mux_out;
  logic [SEL_W-1:0] b_sel;
  logic [N_CH-1:0]  b_data;

  mux_scan_ctrl #(.SETTLE(SETTLE), .OUT_INV(0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ch_mask_i(ch_mask_i), .abort_i(abort_i),
    .busy_o(a_busy), .mux_sel_o(a_sel), .mux_dis_o(a_dis), .mux_out_i(a_mux_out),
    .data_o(a_data), .valid_o(a_valid), .ready_i(ready_i)
  );

  mux_scan_ctrl #(.SETTLE(SETTLE), .OUT_INV(1)) dut_inv (
    .clk(clk), .rst(rst), .start_i(start_i), .ch_mask_i(ch_mask_i), .abort_i(abort_i),
    .busy_o(b_busy), .mux_sel_o(b_sel), .mux_dis_o(b_dis), .mux_out_i(b_mux_out),
    .data_o(b_data), .valid_o(b_valid), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: output shows the wrong level until it has been stable SETTLE cycles.
  logic [SEL_W-1:0] sel_prev = '0;
  logic             dis_prev = 1'b1;
  logic [7:0]       age_q = '0;
  logic [7:0]       age;
  logic             settled;
  assign age     = ((a_sel != sel_prev) || (a_dis != dis_prev)) ? 8'd0 : age_q;
  assign settled = !glitch_en || (int'(age) >= SETTLE);
  always @(posedge clk) begin
    sel_prev <= a_sel;
    dis_prev <= a_dis;
    age_q    <= (age == 8'hFF) ? age : age + 8'd1;
  end
  assign a_mux_out = a_dis ? 1'b0 : (mux_data[a_sel] ^ ~settled);
  assign b_mux_out = b_dis ? 1'b1 : ~(mux_data[b_sel] ^ ~settled);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [N_CH-1:0] data;
    logic [N_CH-1:0] mask;
    int              start_cyc;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: record the select trace during SCAN and score each completed snapshot.
  logic [SEL_W-1:0] trace[$];
  logic [SEL_W-1:0] exp_trace[$];
  logic             valid_prev = 1'b0;
  exp_t             e;
  logic             tr_ok;
  always @(negedge clk) begin
    if (rst) begin
      trace.delete();
      valid_prev = 1'b0;
    end else begin
      if (!a_busy)     trace.delete();
      else if (!a_dis) trace.push_back(a_sel);
      if (a_valid && !valid_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("data_o", 32'(a_data), 32'(e.data));
          check("data_o_inv", 32'(b_data), 32'(e.data));
          check("valid_inv", 32'(b_valid), 32'd1);
          check("latency", 32'(cyc - e.start_cyc), 32'(1 + $countones(e.mask) * HOLD));
          exp_trace.delete();
          for (int ch = 0; ch < N_CH; ch++)
            if (e.mask[ch]) for (int k = 0; k < HOLD; k++) exp_trace.push_back(SEL_W'(ch));
          tr_ok = (trace.size() == exp_trace.size());
          if (tr_ok) for (int k = 0; k < trace.size(); k++) if (trace[k] != exp_trace[k]) tr_ok = 1'b0;
          check("sel_trace", 32'(tr_ok), 32'd1);
        end
      end
      valid_prev = a_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (a_busy && n < 200) begin tick(); n++; end
    if (a_busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 32'(a_busy), 32'd0);
    check({name, "_valid"}, 32'(a_valid), 32'd0);
    check({name, "_dis"}, 32'(a_dis), 32'd1);
  endtask

  // Complete scan; hold cycles of backpressure with ignored start pulses, optional abort on handshake.
  task automatic run_scan(input logic [N_CH-1:0] m, input logic [N_CH-1:0] d, input logic g,
                          input int hold, input logic abort_hs);
    int   n;
    logic ok;
    wait_idle();
    ch_mask_i = m; mux_data = d; glitch_en = g;
    sb_q.push_back('{d & m, m, cyc});
    start_i = 1'b1; tick(); start_i = 1'b0;
    ch_mask_i = N_CH'($urandom);
    n = 0;
    while (!a_valid && n < 200) begin tick(); n++; end
    if (!a_valid) check("valid_timeout", 32'd0, 32'd1);
    ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      start_i = k[0];
      tick();
      if (a_data !== (d & m) || !a_valid || !a_busy) ok = 1'b0;
    end
    start_i = 1'b0;
    if (hold > 0) check("hold_stable", 32'(ok), 32'd1);
    ready_i = 1'b1; abort_i = abort_hs; tick(); ready_i = 1'b0; abort_i = 1'b0;
    check_idle("after_hs");
  endtask

  // Start a scan and cancel it (abort or reset) while in cycle 'at' after the start.
  task automatic cancel_scan(input logic [N_CH-1:0] m, input logic [N_CH-1:0] d, input int at,
                             input logic use_rst);
    logic [N_CH-1:0] p;
    int j;
    wait_idle();
    ch_mask_i = m; mux_data = d; glitch_en = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (at - 1) tick();
    if (use_rst) rst = 1'b1; else abort_i = 1'b1;
    tick();
    rst = 1'b0; abort_i = 1'b0;
    check_idle(use_rst ? "rst_mid" : "abort_mid");
    p = '0; j = 0;
    for (int ch = 0; ch < N_CH; ch++)
      if (m[ch]) begin j++; if (j * HOLD < at) p[ch] = d[ch]; end
    if (use_rst) begin
      check("rst_mid_data", 32'(a_data), 32'd0);
      check("rst_mid_sel", 32'(a_sel), 32'd0);
    end else begin
      check("abort_partial", 32'(a_data), 32'(p));
      check("abort_partial_inv", 32'(b_data), 32'(p));
    end
  endtask

  initial begin
    logic [N_CH-1:0] m, d;
    int unsigned mode;
    repeat (3) tick();
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_sel", 32'(a_sel), 32'd0);
    check("rst_dis", 32'(a_dis), 32'd1);
    check("rst_data", 32'(a_data), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    rst = 1'b0;
    tick();

    run_scan(16'hFFFF, 16'hA5C3, 1'b0, 0, 1'b0);
    run_scan(16'h8011, 16'hFFFF, 1'b0, 0, 1'b0);
    run_scan(16'h0000, 16'hFFFF, 1'b0, 0, 1'b0);
    run_scan(16'h00FF, 16'h0F0F, 1'b0, 0, 1'b0);
    run_scan(16'hFFFF, 16'h5A5A, 1'b1, 20, 1'b0);
    run_scan(16'h8011, 16'hFFFF, 1'b1, 0, 1'b0);
    run_scan(16'h0F00, 16'h3C3C, 1'b0, 2, 1'b1);
    cancel_scan(16'hFFFF, 16'hA5C3, 10, 1'b0);
    cancel_scan(16'hFFFF, 16'hA5C3, 10, 1'b1);
    run_scan(16'hFFFF, 16'hA5C3, 1'b0, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 3);
      d    = N_CH'($urandom);
      case (mode)
        0:       m = N_CH'($urandom);
        1:       m = N_CH'($urandom & $urandom & $urandom);
        2:       m = N_CH'(1) << $urandom_range(0, N_CH - 1);
        default: m = N_CH'($urandom | $urandom);
      endcase
      if (m != '0 && $urandom_range(0, 4) == 0)
        cancel_scan(m, d, $urandom_range(1, $countones(m) * HOLD), 1'b0);
      else
        run_scan(m, d, 1'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 5) == 0));
    end

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
